// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder parameters and FSM state encoding, used by the PE chain,
// its wrapper and the traceback block.
package viterbi_pkg;

    localparam int VT_N_STATES = 4;
    localparam int VT_T_MAX    = 16;
    localparam int VT_FW       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FINAL = 2'd2,
        TRACE = 2'd3
    } vt_state_t;

endpackage

// File: rtl/viterbi_bp_mem.sv
// Backpointer array psi[n][j]: synchronous write, combinational read so the
// traceback can follow one pointer per cycle.
module viterbi_bp_mem #(
    parameter int N_STATES = 4,
    parameter int T_MAX    = 16,
    parameter int IW       = $clog2(N_STATES),
    parameter int TW       = $clog2(T_MAX)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_n,
    input  logic [IW-1:0] wr_j,
    input  logic [IW-1:0] wr_dat,
    input  logic [TW-1:0] rd_n,
    input  logic [IW-1:0] rd_j,
    output logic [IW-1:0] rd_dat
);

    logic [IW-1:0] mem [T_MAX][N_STATES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_n][wr_j] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_n][rd_j];

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: stores backpointers, picks argmax of the final deltas, then
// emits the decoded path from step T-1 down to 0 (first beat 1 cycle after last fin).
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int N_STATES = VT_N_STATES,
    parameter int T_MAX    = VT_T_MAX,
    parameter int FW       = VT_FW,
    parameter int IW       = $clog2(N_STATES),
    parameter int TW       = $clog2(T_MAX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bp_valid,
    input  logic [IW-1:0]        bp_idx,
    input  logic                 bp_last,
    output logic                 bp_ready,
    input  logic                 fin_valid,
    input  logic signed [FW-1:0] fin_val,
    output logic                 fin_ready,
    output logic                 path_valid,
    output logic [IW-1:0]        path_state,
    output logic [TW-1:0]        path_step,
    output logic                 path_last,
    input  logic                 path_ready,
    output logic                 busy,
    output logic                 err
);

    localparam logic [TW:0]   N_LIM  = (TW+1)'(T_MAX);
    localparam logic [IW-1:0] J_LAST = IW'(N_STATES - 1);
    localparam logic [TW-1:0] T_TOP  = TW'(T_MAX - 1);

    vt_state_t            state_q, state_d;
    logic [TW:0]          n_q;
    logic [IW-1:0]        j_q;
    logic [TW-1:0]        t_last_q;
    logic [IW-1:0]        fcnt_q;
    logic [IW-1:0]        arg_q;
    logic signed [FW-1:0] max_q;
    logic [IW-1:0]        s_q;
    logic [TW-1:0]        step_q;
    logic                 err_q;

    logic          bp_fire, fin_take, path_fire;
    logic          ovf, fin_first, fin_gt, fin_done;
    logic [IW-1:0] fin_idx, win_idx;
    logic [TW-1:0] t_load;
    logic          wr_en;
    logic [TW-1:0] wr_n;
    logic [IW-1:0] rd_dat;

    assign bp_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign fin_ready = (state_q == IDLE) || (state_q == FINAL);
    assign bp_fire   = bp_valid && bp_ready;
    // In IDLE a simultaneous bp beat takes priority and the fin beat is left pending.
    assign fin_take  = fin_valid && ((state_q == FINAL) || ((state_q == IDLE) && !bp_valid));
    assign path_fire = path_valid && path_ready;

    // n saturates at T_MAX, so equality flags every beat beyond the array.
    assign ovf    = (n_q == N_LIM);
    assign t_load = ovf ? T_TOP : n_q[TW-1:0];
    assign wr_en  = bp_fire && ((state_q == IDLE) || !ovf);
    assign wr_n   = (state_q == IDLE) ? TW'(1) : n_q[TW-1:0];

    assign fin_first = (state_q == IDLE) || (fcnt_q == '0);
    assign fin_idx   = (state_q == IDLE) ? '0 : fcnt_q;
    assign fin_gt    = fin_val > max_q;
    assign win_idx   = (fin_first || fin_gt) ? fin_idx : arg_q;
    assign fin_done  = (state_q == FINAL) && (fcnt_q == J_LAST);

    viterbi_bp_mem #(
        .N_STATES (N_STATES),
        .T_MAX    (T_MAX),
        .IW       (IW),
        .TW       (TW)
    ) u_bp_mem (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_n   (wr_n),
        .wr_j   ((state_q == IDLE) ? '0 : j_q),
        .wr_dat (bp_idx),
        .rd_n   (step_q),
        .rd_j   (s_q),
        .rd_dat (rd_dat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bp_fire) begin
                    state_d = bp_last ? FINAL : LOAD;
                end else if (fin_take) begin
                    state_d = FINAL;
                end
            end
            LOAD: begin
                if (bp_fire && bp_last) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                if (fin_take && fin_done) begin
                    state_d = TRACE;
                end
            end
            TRACE: begin
                if (path_fire && (step_q == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            j_q      <= '0;
            t_last_q <= '0;
            fcnt_q   <= '0;
            arg_q    <= '0;
            max_q    <= '0;
            s_q      <= '0;
            step_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bp_fire) begin
                        // First beat is n=1, j=0; a last flag here is necessarily misaligned.
                        err_q <= bp_last;
                        n_q   <= (TW+1)'(1);
                        j_q   <= IW'(1);
                        if (bp_last) begin
                            t_last_q <= TW'(1);
                            fcnt_q   <= '0;
                        end
                    end else if (fin_take) begin
                        // A fin beat with no backpointers starts a fresh T=1 sequence.
                        err_q    <= 1'b0;
                        t_last_q <= '0;
                        max_q    <= fin_val;
                        arg_q    <= '0;
                        fcnt_q   <= IW'(1);
                    end
                end
                LOAD: begin
                    if (bp_fire) begin
                        if (ovf) begin
                            err_q <= 1'b1;
                        end
                        if (j_q == J_LAST) begin
                            j_q <= '0;
                            if (!ovf) begin
                                n_q <= n_q + (TW+1)'(1);
                            end
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                        if (bp_last) begin
                            if (j_q != J_LAST) begin
                                err_q <= 1'b1;
                            end
                            t_last_q <= t_load;
                            fcnt_q   <= '0;
                        end
                    end
                end
                FINAL: begin
                    if (fin_take) begin
                        if (fin_first || fin_gt) begin
                            max_q <= fin_val;
                            arg_q <= fin_idx;
                        end
                        fcnt_q <= fcnt_q + IW'(1);
                        if (fin_done) begin
                            s_q    <= win_idx;
                            step_q <= t_last_q;
                        end
                    end
                end
                TRACE: begin
                    if (path_fire && (step_q != '0)) begin
                        s_q    <= rd_dat;
                        step_q <= step_q - TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign path_valid = (state_q == TRACE);
    assign path_state = path_valid ? s_q : '0;
    assign path_step  = path_valid ? step_q : '0;
    assign path_last  = path_valid && (step_q == '0);
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: doc/viterbi_traceback.md
VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 Parameter N_STATES, default 4, number of HMM states (>=2).
REQ-002 Parameter T_MAX, default 16, maximum sequence length in time steps.
REQ-003 Parameter FW, default 16, width of the signed fixed-point final delta values.
REQ-004 Parameter IW, default clog2(N_STATES), state-index width; TW, default clog2(T_MAX), step-index width.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- bp_valid  in  1  backpointer beat valid.
- bp_idx  in  IW  psi[n][j], the argmax from the max-plus PE chain.
- bp_last  in  1  marks the final backpointer beat of a sequence.
- bp_ready  out  1  backpointer beat accepted when high together with bp_valid.
- fin_valid  in  1  final-delta beat valid.
- fin_val  in  FW  delta[T-1][j], signed.
- fin_ready  out  1  final-delta beat accepted when high together with fin_valid.
- path_valid  out  1  decoded path beat valid.
- path_state  out  IW  decoded state.
- path_step  out  TW  time step of path_state.
- path_last  out  1  marks the step-0 beat.
- path_ready  in  1  downstream accepts the path beat.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, FINAL and TRACE.
REQ-007 bp_ready SHALL be 1 in IDLE and LOAD; fin_ready SHALL be 1 in IDLE and FINAL; both SHALL be 0 in TRACE.
REQ-008 Backpointers SHALL arrive j-major within a step (j=0..N_STATES-1), for steps n=1..T-1, and SHALL be written to mem[n][j] (T_MAX x N_STATES x IW).
REQ-009 In IDLE, an accepted bp beat SHALL clear err, be stored as n=1,j=0, and move the FSM to LOAD.
REQ-010 In IDLE, an accepted fin beat with no bp beat SHALL start a T=1 sequence in FINAL; if bp_valid and fin_valid are both high in IDLE, bp wins and the fin beat is not accepted.
REQ-011 In LOAD, j SHALL wrap from N_STATES-1 to 0 and increment n; an accepted bp_last beat SHALL set T=n+1 and move the FSM to FINAL.
REQ-012 bp_last on a beat with j!=N_STATES-1 SHALL set err and SHALL still end loading, with T=n+1.
REQ-013 Beats for n>=T_MAX SHALL be accepted but not written, and SHALL set err.
REQ-014 In FINAL, N_STATES fin beats SHALL be accepted with a running signed maximum.
- Update only when strictly greater, so ties resolve to the lowest index.
- After the last beat, the FSM SHALL enter TRACE with s=argmax and step=T-1.
REQ-015 In TRACE, path_state=s and path_step=step; path_last=1 when step==0.
REQ-016 On a path handshake (path_valid&&path_ready), s SHALL become mem[step][s] and step SHALL decrement; memory is read combinationally, giving up to one beat per cycle.
REQ-017 The handshake on the path_last beat SHALL return the FSM to IDLE; busy SHALL drop in that same cycle.
REQ-018 path_state, path_step and path_last SHALL be held stable while path_valid=1 and path_ready=0.
REQ-019 path_valid SHALL be 1 only in TRACE; first-beat latency is 1 cycle after the last fin handshake.
REQ-020 Sequence length is bounded by T_MAX; when err is set, the trace still runs on the stored data.

Reset
REQ-021 When rst_n=0 at a clock edge:
- FSM goes to IDLE and all counters clear.
- Outputs: path_valid=0, path_state=0, path_step=0, path_last=0, busy=0, err=0.
- Ready outputs take their IDLE values: bp_ready=1, fin_ready=1.
REQ-022 Reset in any state, including mid-LOAD or mid-TRACE, SHALL abort the sequence with no further path beats; memory contents are not cleared.

Structure
REQ-023 N_STATES, T_MAX, FW and the FSM state encoding SHALL live in the shared viterbi package, also used by viterbi_pe and its wrapper.
REQ-024 An optional sub-module viterbi_bp_mem holds the backpointer array: synchronous write, combinational read.

Verification
REQ-025 Basic trace, N_STATES=4, T=3:
- Stimulus: bp step1=(0,0,1,2), step2=(3,1,1,0) with bp_last on the 8th beat; fin=(5,-2,9,9).
- Required path: (state2,step2), (1,1), (0,0,last).
REQ-026 T=1: fin=(-1,-3,-7,-2) with no bp beats -> a single beat state0, step0, path_last=1.
REQ-027 Backpressure: hold path_ready=0 for 3 cycles during REQ-025 -> outputs stable, identical sequence, no beat lost.
REQ-028 Overflow: 16 steps of bp with T_MAX=16 -> err=1 from the first n=16 beat; trace starts at step 15.
REQ-029 Misaligned end: bp_last on j=2 of step 1 -> err=1 and FSM in FINAL.
REQ-030 Reset: rst_n=0 for one cycle on the second TRACE beat -> next cycle path_valid=0, busy=0, bp_ready=1, and a new sequence decodes correctly.
